fxp_add_arbiter: RTL and testbench
==================================

// Module: fxp_add_arbiter
// PURPOSE
// - Shares one Q8.8 signed fixed-point adder (fxp_add instance) among N_REQ requesters.
// - Round-robin arbitration; per-requester valid/ready request ports; one registered result
//   port tagged with the winning requester id.
// - Sits between compute lanes that need occasional adds and the single adder resource.
// PARAMETERS
// - N_REQ       4   number of requesters (2..16)
// - TOTAL_BITS  16  operand/result width, Q8.8 at default
// - ID_W        $clog2(N_REQ)  localparam, width of res_id
// PORTS
// - clk        in   1               rising-edge clock
// - rst        in   1               asynchronous reset, active-high
// - req_valid  in   N_REQ           requester i has an operand pair
// - req_ready  out  N_REQ           one-hot grant; handshake when req_valid[i] & req_ready[i]
// - req_a      in   N_REQ*TOTAL_BITS  operand a of requester i at bits [i*TOTAL_BITS +: TOTAL_BITS]
// - req_b      in   N_REQ*TOTAL_BITS  operand b of requester i, same packing
// - res_valid  out  1               result register holds a valid sum
// - res_ready  in   1               consumer accepts result
// - res_sum    out  TOTAL_BITS      signed Q8.8 sum
// - res_id     out  ID_W            index of requester that produced res_sum
// - res_ovf    out  1               signed overflow occurred for this sum
// BEHAVIOUR
// - Reset (async, rst=1): res_valid=0, res_sum=0, res_id=0, res_ovf=0, rr_ptr=0; req_ready=0 while rst.
// - Output FSM: EMPTY (res_valid=0) / FULL (res_valid=1).
//   EMPTY -> FULL on grant. FULL -> EMPTY on res_ready & ~grant. FULL -> FULL on res_ready & grant (back-to-back).
//   FULL & ~res_ready: hold all res_* stable, no grant.
// - can_accept = ~res_valid | res_ready. req_ready is combinational from req_valid, rr_ptr and can_accept.
// - Grant: when can_accept and |req_valid, grant the first i with req_valid[i], scanning rr_ptr, rr_ptr+1, ... mod N_REQ.
//   req_ready is one-hot or zero; it is never asserted to a requester with req_valid=0.
// - On grant g: rr_ptr <= (g+1) mod N_REQ (wraps N_REQ-1 -> 0). rr_ptr does not change without a grant.
//   Register res_sum <= a_g+b_g, res_id <= g, res_ovf <= overflow, res_valid <= 1.
// - Latency: 1 cycle from handshake to res_valid. Throughput: 1 add/cycle when res_ready is held high.
// - Arithmetic: two's-complement, TOTAL_BITS wide. overflow = (a[MSB]==b[MSB]) & (sum[MSB]!=a[MSB]).
// - Fairness: with all requesters valid continuously, grants rotate 0,1,...,N_REQ-1,0; no requester waits more
//   than N_REQ-1 grants.
// - Requester dropping req_valid before handshake: no grant, no state change; it may re-raise later.
// - Reset mid-operation: pending result discarded; first grant after release goes to lowest valid index from 0.
// CONFIGURATION
// - FXP_SAT_EN defined: on overflow res_sum saturates: positive -> 0x7FFF (+127.996), negative -> 0x8000 (-128.0)
//   (generally max/min signed TOTAL_BITS). res_ovf still = 1.
// - FXP_SAT_EN undefined: res_sum is the wrapped sum; res_ovf = 1 flags the wrap. All other behaviour identical.
// TESTING
// - Single add: req_valid=0001, a0=0x0180 (1.5), b0=0x0240 (2.25), res_ready=1 -> next cycle res_valid=1,
//   res_sum=0x03C0, res_id=0, res_ovf=0.
// - Round-robin: req_valid=1111 held, res_ready=1 -> grants 0,1,2,3,0 on consecutive cycles; res_id follows
//   one cycle later.
// - Backpressure: result pending, res_ready=0 for 3 cycles -> req_ready=0000, res_* stable; res_ready=1 ->
//   new grant in the same cycle.
// - Overflow: a=0x7F00, b=0x0200 -> res_ovf=1; res_sum=0x8100 without FXP_SAT_EN, 0x7FFF with it.
//   Also a=0x8000, b=0xFF00 -> 0x7F00 / 0x8000.
// - Negative no-overflow: a=0xFE80 (-1.5), b=0x0100 (1.0) -> res_sum=0xFF80 (-0.5), res_ovf=0.
// - Reset mid-stream: rst asserted while res_valid=1 and rr_ptr=2 -> immediately res_valid=0, rr_ptr=0;
//   after release req_valid=1111 -> grant 0.

Source files
------------

// File: rtl/fxp_add_arbiter.sv
// ============================================================================
// Module   : fxp_add_arbiter (with helper fxp_add)
// Brief    : Round-robin arbiter that shares one signed fixed-point adder
//            among N_REQ valid/ready requesters. The sum is registered and
//            tagged with the id of the requester that produced it.
//            Optional macro FXP_SAT_EN: saturate the sum on signed overflow.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module fxp_add #(
  parameter int TOTAL_BITS = 16
) (
  input  logic [TOTAL_BITS-1:0] i_a,
  input  logic [TOTAL_BITS-1:0] i_b,
  output logic [TOTAL_BITS-1:0] o_sum,
  output logic                  o_ovf
);
  localparam int MSB = TOTAL_BITS - 1;

  logic [TOTAL_BITS-1:0] w_raw;

  assign w_raw = i_a + i_b;
  assign o_ovf = (i_a[MSB] == i_b[MSB]) & (w_raw[MSB] != i_a[MSB]);

`ifdef FXP_SAT_EN
  localparam logic [TOTAL_BITS-1:0] C_MAX = {1'b0, {(TOTAL_BITS-1){1'b1}}};
  localparam logic [TOTAL_BITS-1:0] C_MIN = {1'b1, {(TOTAL_BITS-1){1'b0}}};

  // Operand sign tells the overflow direction (both operands share it).
  assign o_sum = o_ovf ? (i_a[MSB] ? C_MIN : C_MAX) : w_raw;
`else
  assign o_sum = w_raw;
`endif

endmodule

module fxp_add_arbiter #(
  parameter int N_REQ      = 4,
  parameter int TOTAL_BITS = 16,
  localparam int ID_W      = $clog2(N_REQ)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [N_REQ-1:0]            req_valid,
  output logic [N_REQ-1:0]            req_ready,
  input  logic [N_REQ*TOTAL_BITS-1:0] req_a,
  input  logic [N_REQ*TOTAL_BITS-1:0] req_b,
  output logic                        res_valid,
  input  logic                        res_ready,
  output logic [TOTAL_BITS-1:0]       res_sum,
  output logic [ID_W-1:0]             res_id,
  output logic                        res_ovf
);
  localparam int IW1 = ID_W + 1;

  localparam logic [0:0] ST_EMPTY = 1'b0;
  localparam logic [0:0] ST_FULL  = 1'b1;

  logic [0:0]            r_state;
  logic [ID_W-1:0]       r_ptr;
  logic [TOTAL_BITS-1:0] r_sum;
  logic [ID_W-1:0]       r_id;
  logic                  r_ovf;

  logic                  w_can_accept;
  logic                  w_found;
  logic                  w_grant;
  logic [ID_W-1:0]       w_gnt_id;
  logic [IW1-1:0]        w_idx;
  logic [TOTAL_BITS-1:0] w_a;
  logic [TOTAL_BITS-1:0] w_b;
  logic [TOTAL_BITS-1:0] w_sum;
  logic                  w_ovf;

  assign res_valid = (r_state == ST_FULL);
  assign res_sum   = r_sum;
  assign res_id    = r_id;
  assign res_ovf   = r_ovf;

  assign w_can_accept = ~res_valid | res_ready;

  // Scan from r_ptr upward with wrap; the first valid requester wins.
  always_comb begin
    w_found  = 1'b0;
    w_gnt_id = '0;
    w_idx    = '0;
    for (int k = 0; k < N_REQ; k++) begin
      w_idx = {1'b0, r_ptr} + IW1'(k);
      if (w_idx >= IW1'(N_REQ)) begin
        w_idx = w_idx - IW1'(N_REQ);
      end
      if (!w_found && req_valid[w_idx[ID_W-1:0]]) begin
        w_found  = 1'b1;
        w_gnt_id = w_idx[ID_W-1:0];
      end
    end
  end

  assign w_grant   = ~rst & w_can_accept & w_found;
  assign req_ready = w_grant ? (N_REQ'(1) << w_gnt_id) : '0;

  assign w_a = req_a[w_gnt_id*TOTAL_BITS +: TOTAL_BITS];
  assign w_b = req_b[w_gnt_id*TOTAL_BITS +: TOTAL_BITS];

  fxp_add #(
    .TOTAL_BITS (TOTAL_BITS)
  ) u_fxp_add (
    .i_a   (w_a),
    .i_b   (w_b),
    .o_sum (w_sum),
    .o_ovf (w_ovf)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_EMPTY;
      r_ptr   <= '0;
      r_sum   <= '0;
      r_id    <= '0;
      r_ovf   <= 1'b0;
    end else if (w_grant) begin
      r_state <= ST_FULL;
      r_sum   <= w_sum;
      r_id    <= w_gnt_id;
      r_ovf   <= w_ovf;
      r_ptr   <= (w_gnt_id == ID_W'(N_REQ - 1)) ? '0 : w_gnt_id + ID_W'(1);
    end else if (res_ready) begin
      r_state <= ST_EMPTY;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_fxp_add_arbiter.sv
// ============================================================================
// Module   : tb_fxp_add_arbiter
// Brief    : Directed plus randomised scoreboard bench for fxp_add_arbiter.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fxp_add_arbiter;
  localparam int N = 4;
  localparam int W = 16;

  typedef struct packed {
    logic [W-1:0] sum;
    logic [1:0]   id;
    logic         ovf;
  } exp_t;

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   req_valid;
  logic [N-1:0]   req_ready;
  logic [N*W-1:0] req_a;
  logic [N*W-1:0] req_b;
  logic           res_valid;
  logic           res_ready;
  logic [W-1:0]   res_sum;
  logic [1:0]     res_id;
  logic           res_ovf;

  logic [W-1:0] opa [N];
  logic [W-1:0] opb [N];

  int   checks   = 0;
  int   failures = 0;
  exp_t sb[$];
  int   m_ptr    = 0;

  always #5 clk = ~clk;

  for (genvar gi = 0; gi < N; gi++) begin : g_pack
    assign req_a[gi*W +: W] = opa[gi];
    assign req_b[gi*W +: W] = opb[gi];
  end

  fxp_add_arbiter #(
    .N_REQ      (N),
    .TOTAL_BITS (W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_sum   (res_sum),
    .res_id    (res_id),
    .res_ovf   (res_ovf)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic exp_t model(input int g);
    exp_t         e;
    logic [W-1:0] s;
    s     = opa[g] + opb[g];
    e.ovf = (opa[g][W-1] == opb[g][W-1]) && (s[W-1] != opa[g][W-1]);
`ifdef FXP_SAT_EN
    if (e.ovf) s = opa[g][W-1] ? 16'h8000 : 16'h7FFF;
`endif
    e.sum = s;
    e.id  = 2'(g);
    return e;
  endfunction

  // One clock: check the output register and grant mid-cycle, then advance.
  task automatic step();
    bit       cap;
    int       g;
    int       idx;
    exp_t     e;
    logic [N-1:0] exp_rdy;
    @(negedge clk);
    cap = (sb.size() == 0) || res_ready;
    if (sb.size() == 0) begin
      check("res_valid_idle", 32'(res_valid), 32'd0);
    end else begin
      check("res_valid_full", 32'(res_valid), 32'd1);
      check("res_sum", 32'(res_sum), 32'(sb[0].sum));
      check("res_id", 32'(res_id), 32'(sb[0].id));
      check("res_ovf", 32'(res_ovf), 32'(sb[0].ovf));
      if (res_ready) e = sb.pop_front();
    end
    g = -1;
    if (cap) begin
      for (int k = 0; k < N; k++) begin
        idx = (m_ptr + k) % N;
        if (g < 0 && req_valid[idx]) g = idx;
      end
    end
    exp_rdy = (g >= 0) ? N'(1 << g) : '0;
    check("req_ready", 32'(req_ready), 32'(exp_rdy));
    if (g >= 0) begin
      sb.push_back(model(g));
      m_ptr = (g + 1) % N;
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst       = 1'b1;
    req_valid = 4'b1111;
    res_ready = 1'b1;
    for (int i = 0; i < N; i++) begin
      opa[i] = '0;
      opb[i] = '0;
    end
    repeat (2) @(posedge clk);
    #1;
    check("rst_res_valid", 32'(res_valid), 32'd0);
    check("rst_res_sum", 32'(res_sum), 32'd0);
    check("rst_res_id", 32'(res_id), 32'd0);
    check("rst_res_ovf", 32'(res_ovf), 32'd0);
    check("rst_req_ready", 32'(req_ready), 32'd0);
    rst       = 1'b0;
    req_valid = 4'b0000;

    // Single add: 1.5 + 2.25
    opa[0] = 16'h0180; opb[0] = 16'h0240; req_valid = 4'b0001;
    step();
    check("single_sum", 32'(res_sum), 32'h03C0);
    check("single_ovf", 32'(res_ovf), 32'd0);
    req_valid = 4'b0000;
    step();

    // Round-robin with everyone valid
    for (int i = 0; i < N; i++) begin
      opa[i] = 16'(16'h0100 * (i + 1));
      opb[i] = 16'(16'h0010 * (i + 3));
    end
    req_valid = 4'b1111;
    repeat (6) step();
    req_valid = 4'b0000;
    step();

    // Backpressure: result held for three cycles, then back-to-back grant
    req_valid = 4'b0001;
    step();
    res_ready = 1'b0;
    req_valid = 4'b1111;
    repeat (3) step();
    res_ready = 1'b1;
    step();
    req_valid = 4'b0000;
    step();

    // Overflow in both directions and a negative no-overflow add
    opa[1] = 16'h7F00; opb[1] = 16'h0200; req_valid = 4'b0010;
    step();
`ifdef FXP_SAT_EN
    check("ovf_pos_sum", 32'(res_sum), 32'h7FFF);
`else
    check("ovf_pos_sum", 32'(res_sum), 32'h8100);
`endif
    check("ovf_pos_flag", 32'(res_ovf), 32'd1);
    opa[2] = 16'h8000; opb[2] = 16'hFF00; req_valid = 4'b0100;
    step();
`ifdef FXP_SAT_EN
    check("ovf_neg_sum", 32'(res_sum), 32'h8000);
`else
    check("ovf_neg_sum", 32'(res_sum), 32'h7F00);
`endif
    check("ovf_neg_flag", 32'(res_ovf), 32'd1);
    opa[3] = 16'hFE80; opb[3] = 16'h0100; req_valid = 4'b1000;
    step();
    check("neg_sum", 32'(res_sum), 32'hFF80);
    check("neg_ovf", 32'(res_ovf), 32'd0);
    req_valid = 4'b0000;
    step();

    // Reset while a result is pending and the pointer sits at 2
    req_valid = 4'b0010;
    step();
    req_valid = 4'b1111;
    res_ready = 1'b0;
    check("pre_rst_valid", 32'(res_valid), 32'd1);
    rst = 1'b1;
    #1;
    check("mid_rst_valid", 32'(res_valid), 32'd0);
    check("mid_rst_ready", 32'(req_ready), 32'd0);
    sb.delete();
    m_ptr = 0;
    @(posedge clk);
    #1;
    rst       = 1'b0;
    res_ready = 1'b1;
    step();
    check("post_rst_id", 32'(res_id), 32'd0);
    req_valid = 4'b0000;
    step();

    // Random traffic, including requesters dropping valid before a grant
    for (int n = 0; n < 60; n++) begin
      req_valid = 4'($urandom_range(0, 15));
      res_ready = ($urandom_range(0, 3) != 0);
      for (int i = 0; i < N; i++) begin
        opa[i] = 16'($urandom);
        opb[i] = 16'($urandom);
      end
      step();
    end
    req_valid = 4'b0000;
    res_ready = 1'b1;
    repeat (2) step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
